// File: rtl/serdes_frame_arbiter.sv
// Round-robin frame arbiter: locks onto one requester for a full N_SAMPLES-word frame
// and forwards its words combinationally, tagged with source index and last-beat flag.
module serdes_frame_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int N_REQ     = 4,
  localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BEAT_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_en,
  input  logic [N_REQ*BIT_WIDTH-1:0] recv_msg,
  input  logic [N_REQ-1:0]           recv_val,
  output logic [N_REQ-1:0]           recv_rdy,
  output logic [BIT_WIDTH-1:0]       send_msg,
  output logic                       send_val,
  input  logic                       send_rdy,
  output logic [SRC_W-1:0]           send_src,
  output logic                       send_last
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_SAMPLES - 1);

  state_t            state, state_n;
  logic [SRC_W-1:0]  grant, grant_n;
  logic [SRC_W-1:0]  rr_ptr, rr_ptr_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [SRC_W-1:0]  pick;
  logic              pick_found;
  logic [N_REQ-1:0]  eligible;
  logic              handshake;

  // Index addition modulo N_REQ, explicit so non-power-of-two counts wrap correctly.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return SRC_W'(sum);
  endfunction

  // Scan from the farthest offset back to rr_ptr so the closest eligible index wins.
  always_comb begin
    eligible   = recv_val & req_en;
    pick_found = 1'b0;
    pick       = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick       = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    send_val  = 1'b0;
    send_msg  = '0;
    send_src  = grant;
    send_last = 1'b0;
    recv_rdy  = '0;
    if (state == BURST) begin
      send_val        = recv_val[grant];
      send_msg        = recv_msg[grant*BIT_WIDTH +: BIT_WIDTH];
      send_last       = (beat == LAST_BEAT);
      recv_rdy[grant] = send_rdy;
    end
  end

  assign handshake = send_val & send_rdy;

  // A stalled or idle-valid owner keeps the lock; only the final handshake releases it.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    beat_n   = beat;
    rr_ptr_n = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = BURST;
          grant_n = pick;
          beat_n  = '0;
        end
      end
      BURST: begin
        if (handshake) begin
          if (beat == LAST_BEAT) begin
            state_n  = IDLE;
            beat_n   = '0;
            rr_ptr_n = wrap_add(grant, 1);
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      beat   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      beat   <= beat_n;
      rr_ptr <= rr_ptr_n;
    end
  end

endmodule

// File: tb/tb_serdes_frame_arbiter.sv
// Bench for serdes_frame_arbiter: a 4-requester/8-word instance checked against a frame-level
// reference model, plus a 3-requester/1-word instance for masking and single-word frames.
module tb_serdes_frame_arbiter;

  localparam int BW = 32;
  localparam int NS = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_reset, a_send_rdy, a_send_val, a_send_last;
  logic [NR-1:0]   a_en, a_val, a_rdy;
  logic [NR*BW-1:0] a_msg;
  logic [BW-1:0]   a_send_msg;
  logic [1:0]      a_send_src;

  serdes_frame_arbiter #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .N_REQ(NR)) dut_a (
    .clk(clk), .reset(a_reset), .req_en(a_en), .recv_msg(a_msg), .recv_val(a_val),
    .recv_rdy(a_rdy), .send_msg(a_send_msg), .send_val(a_send_val), .send_rdy(a_send_rdy),
    .send_src(a_send_src), .send_last(a_send_last)
  );

  logic        b_reset, b_send_rdy, b_send_val, b_send_last;
  logic [2:0]  b_en, b_val, b_rdy;
  logic [23:0] b_msg;
  logic [7:0]  b_send_msg;
  logic [1:0]  b_send_src;

  serdes_frame_arbiter #(.BIT_WIDTH(8), .N_SAMPLES(1), .N_REQ(3)) dut_b (
    .clk(clk), .reset(b_reset), .req_en(b_en), .recv_msg(b_msg), .recv_val(b_val),
    .recv_rdy(b_rdy), .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(b_send_rdy),
    .send_src(b_send_src), .send_last(b_send_last)
  );

  int checks = 0;
  int passes = 0;

  // Frame-level reference: who owns the link, how many words of the frame went, who is next.
  bit  m_busy  = 1'b0;
  int  m_owner = 0;
  int  m_sent  = 0;
  int  m_next  = 0;

  logic [31:0] prod_base [NR] = '{32'h1000, 32'h2000, 32'h10, 32'h3000};
  int          prod_cnt  [NR] = '{0, 0, 0, 0};

  logic          obs_val, obs_last;
  logic [1:0]    obs_src;
  logic [NR-1:0] obs_rdy;
  logic [31:0]   obs_msg;

  logic       bobs_val, bobs_last;
  logic [1:0] bobs_src;
  logic [2:0] bobs_rdy;
  logic [7:0] bobs_msg;

  typedef struct {
    logic        rst;
    logic [3:0]  val;
    logic        v;
    logic [1:0]  src;
    logic        last;
    logic [3:0]  rdy;
    logic [31:0] msg;
  } vec_t;

  vec_t vecs [12];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input logic ev, input int es, input logic el,
                             input logic [NR-1:0] er, input logic [31:0] em);
    checkVal("model send_val", 32'(obs_val), 32'(ev));
    checkVal("model send_src", 32'(obs_src), 32'(es));
    checkVal("model send_last", 32'(obs_last), 32'(el));
    checkVal("model recv_rdy", 32'(obs_rdy), 32'(er));
    checkVal("model send_msg", obs_msg, em);
  endtask

  task automatic applyStimulus(input logic rst, input logic [NR-1:0] en,
                               input logic [NR-1:0] val, input logic rdy);
    logic          exp_val, exp_last;
    logic [NR-1:0] exp_rdy;
    logic [31:0]   exp_msg;
    int            exp_src;
    bit            found;
    a_reset    = rst;
    a_en       = en;
    a_val      = val;
    a_send_rdy = rdy;
    for (int i = 0; i < NR; i++) a_msg[i*BW +: BW] = prod_base[i] + 32'(prod_cnt[i]);
    @(negedge clk);
    exp_val  = 1'b0;
    exp_last = 1'b0;
    exp_rdy  = '0;
    exp_msg  = '0;
    exp_src  = m_owner;
    if (m_busy) begin
      exp_val          = val[m_owner];
      exp_msg          = prod_base[m_owner] + 32'(prod_cnt[m_owner]);
      exp_last         = (m_sent == NS - 1);
      exp_rdy[m_owner] = rdy;
    end
    obs_val  = a_send_val;
    obs_src  = a_send_src;
    obs_last = a_send_last;
    obs_rdy  = a_rdy;
    obs_msg  = a_send_msg;
    checkOutput(exp_val, exp_src, exp_last, exp_rdy, exp_msg);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_sent = 0; m_next = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        if (!found && val[(m_next + k) % NR] && en[(m_next + k) % NR]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = (m_next + k) % NR;
          m_sent  = 0;
        end
      end
    end else if (val[m_owner] && rdy) begin
      m_sent++;
      if (m_sent == NS) begin
        m_busy = 1'b0;
        m_sent = 0;
        m_next = (m_owner + 1) % NR;
      end
    end
    for (int i = 0; i < NR; i++) if (val[i] && obs_rdy[i]) prod_cnt[i]++;
    #1;
  endtask

  task automatic stepB(input logic rst, input logic [2:0] en, input logic [2:0] val);
    b_reset    = rst;
    b_en       = en;
    b_val      = val;
    b_send_rdy = 1'b1;
    @(negedge clk);
    bobs_val  = b_send_val;
    bobs_src  = b_send_src;
    bobs_last = b_send_last;
    bobs_rdy  = b_rdy;
    bobs_msg  = b_send_msg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs, cyc;
    int b_order [3] = '{2, 0, 2};
    int b_alt   [4] = '{0, 1, 0, 1};

    a_reset = 1'b1; a_en = '0; a_val = '0; a_send_rdy = 1'b0; a_msg = '0;
    b_reset = 1'b1; b_en = '0; b_val = '0; b_send_rdy = 1'b0; b_msg = {8'hA2, 8'hA1, 8'hA0};

    // Single requester 2 sending 0x10..0x17, then re-arbitrating onto itself.
    vecs[0] = '{rst: 1'b1, val: 4'b0000, v: 1'b0, src: 2'd0, last: 1'b0, rdy: 4'b0000, msg: 32'h0};
    vecs[1] = '{rst: 1'b0, val: 4'b0100, v: 1'b0, src: 2'd0, last: 1'b0, rdy: 4'b0000, msg: 32'h0};
    for (int k = 0; k < 8; k++)
      vecs[2+k] = '{rst: 1'b0, val: 4'b0100, v: 1'b1, src: 2'd2, last: (k == 7),
                    rdy: 4'b0100, msg: 32'h10 + 32'(k)};
    vecs[10] = '{rst: 1'b0, val: 4'b0100, v: 1'b0, src: 2'd2, last: 1'b0, rdy: 4'b0000, msg: 32'h0};
    vecs[11] = '{rst: 1'b0, val: 4'b0100, v: 1'b1, src: 2'd2, last: 1'b0, rdy: 4'b0100, msg: 32'h18};

    for (int r = 0; r < 12; r++) begin
      applyStimulus(vecs[r].rst, 4'hF, vecs[r].val, 1'b1);
      checkVal("tbl send_val", 32'(obs_val), 32'(vecs[r].v));
      checkVal("tbl send_src", 32'(obs_src), 32'(vecs[r].src));
      checkVal("tbl send_last", 32'(obs_last), 32'(vecs[r].last));
      checkVal("tbl recv_rdy", 32'(obs_rdy), 32'(vecs[r].rdy));
      checkVal("tbl send_msg", obs_msg, vecs[r].msg);
    end

    // Round-robin with everyone valid: frames 0,1,2,3,0 separated by one bubble.
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      applyStimulus(1'b0, 4'hF, 4'hF, 1'b1);
      checkVal("rr gap send_val", 32'(obs_val), 32'd0);
      for (int k = 0; k < NS; k++) begin
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b1);
        checkVal("rr send_val", 32'(obs_val), 32'd1);
        checkVal("rr send_src", 32'(obs_src), 32'(f % NR));
        checkVal("rr send_last", 32'(obs_last), 32'(k == NS - 1));
      end
    end

    // Backpressure on a frame from requester 1: words hold while stalled.
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < NR; i++) prod_cnt[i] = 0;
    applyStimulus(1'b0, 4'hF, 4'b0010, 1'b1);
    hs  = 0;
    cyc = 0;
    while (hs < NS && cyc < 40) begin
      applyStimulus(1'b0, 4'hF, 4'b0010, (cyc % 2) == 0);
      checkVal("bp send_src", 32'(obs_src), 32'd1);
      checkVal("bp send_msg", obs_msg, prod_base[1] + 32'(hs));
      checkVal("bp send_last", 32'(obs_last), 32'(hs == NS - 1));
      if (obs_val && (cyc % 2) == 0) hs++;
      cyc++;
    end
    checkVal("bp handshakes in budget", 32'(hs), 32'(NS));
    applyStimulus(1'b0, 4'hF, 4'b0010, 1'b1);
    checkVal("bp idle after frame", 32'(obs_val), 32'd0);

    // Reset in the middle of a frame from requester 3.
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'hF, 4'b1000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'hF, 4'b1000, 1'b1);
      checkVal("mid send_src", 32'(obs_src), 32'd3);
    end
    applyStimulus(1'b1, 4'hF, 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'hF, 4'b1001, 1'b1);
    checkVal("mid reset send_val", 32'(obs_val), 32'd0);
    checkVal("mid reset recv_rdy", 32'(obs_rdy), 32'd0);
    applyStimulus(1'b0, 4'hF, 4'b1001, 1'b1);
    checkVal("mid regrant send_src", 32'(obs_src), 32'd0);
    checkVal("mid regrant send_val", 32'(obs_val), 32'd1);

    // Random traffic, masks and resets against the reference model.
    applyStimulus(1'b1, 4'hF, 4'h0, 1'b1);
    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 59) == 0, 4'($urandom), 4'($urandom | $urandom),
                    $urandom_range(0, 3) != 0);
    a_reset = 1'b1;

    // Three requesters, requester 1 masked, one-word frames.
    stepB(1'b1, 3'b101, 3'b111);
    stepB(1'b0, 3'b101, 3'b111);
    checkVal("mask first idle", 32'(bobs_val), 32'd0);
    stepB(1'b0, 3'b101, 3'b111);
    checkVal("mask first src", 32'(bobs_src), 32'd0);
    checkVal("mask first last", 32'(bobs_last), 32'd1);
    for (int f = 0; f < 3; f++) begin
      stepB(1'b0, 3'b101, 3'b111);
      checkVal("mask gap send_val", 32'(bobs_val), 32'd0);
      checkVal("mask gap recv_rdy", 32'(bobs_rdy), 32'd0);
      stepB(1'b0, 3'b101, 3'b111);
      checkVal("mask send_src", 32'(bobs_src), 32'(b_order[f]));
      checkVal("mask send_last", 32'(bobs_last), 32'd1);
      checkVal("mask recv_rdy", 32'(bobs_rdy), 32'(3'b001 << b_order[f]));
      checkVal("mask send_msg", 32'(bobs_msg), 32'h A0 + 32'(b_order[f]));
    end

    // Two requesters alternating single-word frames, one word every two cycles.
    stepB(1'b1, 3'b011, 3'b011);
    for (int f = 0; f < 4; f++) begin
      stepB(1'b0, 3'b011, 3'b011);
      checkVal("ns1 gap send_val", 32'(bobs_val), 32'd0);
      stepB(1'b0, 3'b011, 3'b011);
      checkVal("ns1 send_val", 32'(bobs_val), 32'd1);
      checkVal("ns1 send_src", 32'(bobs_src), 32'(b_alt[f]));
      checkVal("ns1 send_last", 32'(bobs_last), 32'd1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
